// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-2 demultiplexer.
package demux_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready output handshake and a pop counter.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  input  logic              ready,
  output logic              free,
  output logic [CNT_W-1:0]  count
);
  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop;

  assign pop  = (state_q == FULL) && ready;
  assign free = (state_q == EMPTY) || pop;

  // Push is gated by free upstream, so a push always lands in an empty or draining slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (pop) begin
      state_d = EMPTY;
      cnt_d   = cnt_q + 1'b1;
    end
    if (push) begin
      state_d = FULL;
      data_d  = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign count = cnt_q;
endmodule

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer: steers each accepted word to slot A or B by in_sel.
module demux_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  input  logic              a_ready,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  input  logic              b_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);
  logic a_free, b_free, sel_b, xfer;

  assign sel_b    = (in_sel == SEL_B);
  // Only the selected slot can stall the producer.
  assign in_ready = sel_b ? b_free : a_free;
  assign xfer     = in_valid && in_ready;

  demux_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_a (
    .clk(clk), .reset(reset),
    .push(xfer && !sel_b), .push_data(in_data),
    .valid(a_valid), .data(a_data), .ready(a_ready),
    .free(a_free), .count(a_count)
  );

  demux_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_b (
    .clk(clk), .reset(reset),
    .push(xfer && sel_b), .push_data(in_data),
    .valid(b_valid), .data(b_data), .ready(b_ready),
    .free(b_free), .count(b_count)
  );
endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg; a CNT_W=4 twin shares the stimulus for the wrap check.
module tb_demux_reg;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_sel, a_ready, b_ready;
  logic [63:0] in_data;
  logic        in_ready, a_valid, b_valid;
  logic [63:0] a_data, b_data;
  logic [15:0] a_count, b_count;
  logic        w_in_ready, w_a_valid, w_b_valid;
  logic [63:0] w_a_data, w_b_data;
  logic [3:0]  w_a_count, w_b_count;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  demux_reg #(.DATA_W(64), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .in_sel(in_sel),
    .a_valid(w_a_valid), .a_data(w_a_data), .a_ready(a_ready),
    .b_valid(w_b_valid), .b_data(w_b_data), .b_ready(b_ready),
    .a_count(w_a_count), .b_count(w_b_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b1; b_ready = 1'b1;

    // Reset state
    do_reset();
    settle();
    chk("rst a_valid", a_valid, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst a_data", a_data, 0);
    chk("rst b_data", b_data, 0);
    chk("rst a_count", a_count, 0);
    chk("rst b_count", b_count, 0);
    chk("rst in_ready", in_ready, 1);

    // Single word to A
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h8000_0000_0000_0000;
    settle();
    chk("one in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("one a_valid", a_valid, 1);
    chk("one a_data", a_data, 64'h8000_0000_0000_0000);
    chk("one b_valid", b_valid, 0);
    tick();
    chk("one a_count", a_count, 1);
    chk("one a_valid drained", a_valid, 0);
    chk("one b_valid after", b_valid, 0);

    // Alternating select, both consumers ready
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sel = (i % 2 == 0); in_data = 64'(i);
      settle();
      chk("alt in_ready", in_ready, 1);
      tick();
      if (i % 2 == 1) begin
        chk("alt a_valid", a_valid, 1);
        chk("alt a_data", a_data, 64'(i));
        chk("alt b_valid", b_valid, 0);
      end else begin
        chk("alt b_valid", b_valid, 1);
        chk("alt b_data", b_data, 64'(i));
        chk("alt a_valid", a_valid, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("alt a_count", a_count, 4);
    chk("alt b_count", b_count, 4);

    // Backpressure on B with A still flowing
    b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 64'h4000_0000_0000_0000;
    tick();
    chk("bp b_valid", b_valid, 1);
    chk("bp b_data", b_data, 64'h4000_0000_0000_0000);
    in_sel = 1'b0; in_data = 64'h0000_0000_0000_00A5;
    settle();
    chk("ind in_ready", in_ready, 1);
    tick();
    chk("ind a_valid", a_valid, 1);
    chk("ind a_data", a_data, 64'hA5);
    chk("ind b_still", b_valid, 1);
    in_sel = 1'b1; in_data = 64'hC000_0000_0000_0000;
    settle();
    chk("bp in_ready low", in_ready, 0);
    tick();
    chk("bp b_hold", b_data, 64'h4000_0000_0000_0000);
    chk("bp a_count", a_count, 5);
    chk("bp b_count held", b_count, 4);
    b_ready = 1'b1;
    settle();
    chk("bp in_ready raised", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp refill valid", b_valid, 1);
    chk("bp refill data", b_data, 64'hC000_0000_0000_0000);
    chk("bp b_count 5", b_count, 5);
    tick();
    chk("bp drained", b_valid, 0);
    chk("bp b_count 6", b_count, 6);

    // Back-to-back A words, counter wrap on the 4-bit twin
    do_reset();
    in_valid = 1'b1; in_sel = 1'b0; a_ready = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      in_data = 64'(e);
      tick();
      chk("b2b a_data", a_data, 64'(e));
      if (e >= 16) chk("wrap w_a_count", w_a_count, 64'((e - 1) % 16));
    end
    in_valid = 1'b0;
    tick();
    chk("wrap w_a_count 17", w_a_count, 1);
    chk("wrap a_count 17", a_count, 17);
    chk("wrap a_valid", a_valid, 0);

    // Reset with both slots full
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h11;
    tick();
    in_sel = 1'b1; in_data = 64'h22;
    tick();
    in_valid = 1'b0;
    chk("mid a_full", a_valid, 1);
    chk("mid b_full", b_valid, 1);
    do_reset();
    settle();
    chk("mid a_valid", a_valid, 0);
    chk("mid b_valid", b_valid, 0);
    chk("mid a_data", a_data, 0);
    chk("mid b_data", b_data, 0);
    chk("mid a_count", a_count, 0);
    chk("mid b_count", b_count, 0);
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    chk("mid no deliver a", a_count, 0);
    chk("mid no deliver b", b_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
